// File: rtl/serial_chunk_adder.sv
// Multi-cycle ripple adder: A = x + y + cin, CHUNK bits per clock, start/done handshake.
// Optional registered reduction flags of A are built when REDUCE_FLAGS_EN is defined.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] A,
    output logic             cout,
    output logic             all_ones,
    output logic             any_one,
    output logic             is_zero,
    output logic             not_all
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state;
    logic [WIDTH-1:0]       xs;
    logic [WIDTH-1:0]       ys;
    logic [WIDTH-1:0]       ps;
    logic                   c;
    logic [KW-1:0]          k;
    logic [CHUNK:0]         chunk_sum;
    logic [WIDTH+CHUNK-1:0] ps_cat;
    logic [WIDTH-1:0]       ps_next;
    logic                   last;

    // Operands shift right so the active chunk is always the low slice; the
    // partial sum fills in from the top, landing fully aligned after NCH steps.
    always_comb begin
        chunk_sum = {1'b0, xs[CHUNK-1:0]} + {1'b0, ys[CHUNK-1:0]} + {{CHUNK{1'b0}}, c};
        ps_cat    = {chunk_sum[CHUNK-1:0], ps};
        ps_next   = ps_cat[WIDTH+CHUNK-1:CHUNK];
        last      = (k == KW'(NCH - 1));
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            xs    <= '0;
            ys    <= '0;
            ps    <= '0;
            c     <= 1'b0;
            k     <= '0;
            A     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xs    <= x;
                        ys    <= y;
                        c     <= cin;
                        k     <= '0;
                        ps    <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    xs <= xs >> CHUNK;
                    ys <= ys >> CHUNK;
                    c  <= chunk_sum[CHUNK];
                    ps <= ps_next;
                    k  <= k + KW'(1);
                    if (last) begin
                        A     <= ps_next;
                        cout  <= chunk_sum[CHUNK];
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef REDUCE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            all_ones <= 1'b0;
            any_one  <= 1'b0;
            is_zero  <= 1'b1;
            not_all  <= 1'b1;
        end else if (state == S_RUN && last) begin
            all_ones <= &ps_next;
            any_one  <= |ps_next;
            is_zero  <= ~|ps_next;
            not_all  <= ~&ps_next;
        end
    end
`else
    assign all_ones = 1'b0;
    assign any_one  = 1'b0;
    assign is_zero  = 1'b0;
    assign not_all  = 1'b0;
`endif

endmodule
